pipeline_stall_ctrl: RTL
========================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (branch resolved in ID).
//  Detects load-use and branch-operand hazards and counts out multi-cycle stalls.
//  Issues PC/IF-ID enables, IF-ID flush and ID-EX bubble; handshakes the mult/div unit.
//  Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//  MD_TIMEOUT  64  max MD_WAIT cycles before abort (md_error set)
//  CNT_W       32  width of stall_cycles counter
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  id_rs        in   5      Rs of instruction in IF/ID
//  id_rt        in   5      Rt of instruction in IF/ID
//  id_uses_rt   in   1      ID instruction reads Rt
//  id_is_branch in   1      ID instruction is beq/bne
//  id_is_jump   in   1      ID instruction is j/jal/jr
//  id_is_md     in   1      ID instruction is mult/div
//  branch_taken in   1      ID branch comparison result
//  ex_rd        in   5      destination reg in ID/EX
//  ex_reg_write in   1      ID/EX RegWrite
//  ex_mem_read  in   1      ID/EX MemRead
//  mem_rd       in   5      destination reg in EX/MEM
//  mem_mem_read in   1      EX/MEM MemRead
//  md_done      in   1      mult/div result ready (1-cycle pulse)
//  pc_en        out  1      PC write enable
//  ifid_en      out  1      IF/ID write enable
//  ifid_flush   out  1      zero IF/ID on next edge
//  idex_bubble  out  1      insert NOP into ID/EX on next edge
//  md_start     out  1      1-cycle start pulse to mult/div unit
//  md_error     out  1      sticky: MD_TIMEOUT expired
//  stall_cycles out  CNT_W  count of cycles with pc_en==0 (saturating)
// BEHAVIOUR
//  Match(r) = r!=0 && (r==id_rs || (id_uses_rt && r==id_rt)).
//  Stall length L, evaluated in RUN, first rule wins:
//   id_is_branch && ex_mem_read && Match(ex_rd)   -> L=2
//   id_is_branch && ex_reg_write && Match(ex_rd)  -> L=1
//   id_is_branch && mem_mem_read && Match(mem_rd) -> L=1
//   ex_mem_read && Match(ex_rd)                   -> L=1 (load-use)
//   else L=0.
//  Stall cycle outputs: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
//  FSM states RUN, STALL, MD_WAIT; reset -> RUN.
//   RUN, L>0: stall outputs this cycle (Mealy); L==2 -> STALL with cnt=1, else stay RUN.
//   RUN, L==0, id_is_md: md_start=1, stall outputs, -> MD_WAIT, tmo=0.
//   RUN, L==0, !md: pc_en=ifid_en=1, idex_bubble=0;
//    ifid_flush=1 iff id_is_jump || (id_is_branch && branch_taken).
//   STALL: stall outputs; cnt-1; -> RUN when cnt reaches 0 (re-evaluate there).
//   MD_WAIT: stall outputs; md_done=1 -> RUN with pc_en=ifid_en=1, idex_bubble=0 that cycle;
//    tmo==MD_TIMEOUT-1 without md_done -> md_error=1, -> RUN.
//  branch_taken/id_is_jump ignored in any stall cycle (no flush while stalled).
//  md_done sampled only in MD_WAIT; md_done in the md_start cycle is ignored.
//  Priority: rst > data hazard > md issue > flush.
//  rst=1: pc_en=ifid_en=0, ifid_flush=1, idex_bubble=1, md_start=0, md_error=0,
//   stall_cycles=0, cnt=tmo=0, state RUN; mid-stall/mid-MD reset abandons the operation.
//  stall_cycles increments every non-reset cycle with pc_en==0; holds at all-ones.
// STRUCTURE
//  pipe_ctrl_defs.vh: state encodings (RUN/STALL/MD_WAIT), L constants, REG_ZERO=5'd0.
//  Sub-module pipe_dep_cmp: combinational Match() for one (rd,valid) vs (rs,rt,uses_rt);
//   instantiated 3x (EX-load, EX-alu, MEM-load). Rest is one FSM + counters.
// TESTING
//  ex_mem_read=1,ex_rd=8,id_rs=8 -> 1 stall cycle (pc_en=0,idex_bubble=1), stall_cycles=1.
//  beq, ex_mem_read=1,ex_rd=9=id_rt,uses_rt -> 2 consecutive stall cycles, then pc_en=1.
//  beq, ex_reg_write=1,ex_rd=0=id_rs -> no stall (r0 exempt); taken -> ifid_flush=1 same cycle.
//  id_is_md=1 -> md_start 1 cycle; md_done after 5 cycles -> 6 stall cycles, release on done.
//  MD_TIMEOUT=8, no md_done -> md_error=1 after 8 MD_WAIT cycles, FSM back to RUN.
//  rst asserted in STALL (cnt=1) and in MD_WAIT -> next cycle RUN, stall_cycles=0, md_error=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//   FSM state encoding, stall-length constants, the hard-wired zero register
//   and the hazard-priority helper that turns comparator hits into a stall
//   length.
// -----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_MD_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] L_NONE = 2'd0;
  localparam logic [1:0] L_ONE  = 2'd1;
  localparam logic [1:0] L_TWO  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Ordered hazard rules, first match wins. A branch resolved in ID needs its
  // operands one stage earlier than an ALU op, so a load in EX costs it two
  // cycles and an ALU result in EX or a load in MEM costs it one.
  function automatic logic [1:0] stall_len(
    input logic is_branch,
    input logic ex_load_hit,
    input logic ex_alu_hit,
    input logic mem_load_hit
  );
    logic [1:0] len;
    len = L_NONE;
    if (is_branch && ex_load_hit) begin
      len = L_TWO;
    end else if (is_branch && ex_alu_hit) begin
      len = L_ONE;
    end else if (is_branch && mem_load_hit) begin
      len = L_ONE;
    end else if (ex_load_hit) begin
      len = L_ONE;
    end
    return len;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_dep_cmp.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl_dep_cmp
//   Register dependency comparator: flags when a producing stage (rd_i,
//   valid_i) writes a register read by the instruction in ID. Register 0 is
//   never a dependency.
// Ports
//   rd_i       producer destination register
//   valid_i    producer qualifier (RegWrite / MemRead of that stage)
//   rs_i       ID source register Rs
//   rt_i       ID source register Rt
//   uses_rt_i  ID instruction actually reads Rt
//   hit_o      dependency present
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl_dep_cmp
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [4:0] rd_i,
  input  logic       valid_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       uses_rt_i,
  output logic       hit_o
);

  assign hit_o = valid_i && (rd_i != REG_ZERO) &&
                 ((rd_i == rs_i) || (uses_rt_i && (rd_i == rt_i)));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Stall/flush sequencer for a 5-stage MIPS pipeline with branches resolved
//   in ID. Detects load-use and branch-operand hazards, counts out multi-cycle
//   stalls, handshakes the mult/div unit and keeps a saturating count of
//   cycles in which the PC was held.
// Parameters
//   MD_TIMEOUT  MD_WAIT cycles allowed before the mult/div wait is abandoned
//   CNT_W       width of stall_cycles_o
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   id_*_i                   decoded fields of the instruction in IF/ID
//   branch_taken_i           ID branch comparison result
//   ex_*_i, mem_*_i          destination/control of ID/EX and EX/MEM
//   md_done_i                mult/div result ready pulse
//   pc_en_o, ifid_en_o       PC and IF/ID write enables
//   ifid_flush_o             zero IF/ID on next edge
//   idex_bubble_o            insert NOP into ID/EX on next edge
//   md_start_o               start pulse to mult/div unit
//   md_error_o               sticky mult/div timeout flag
//   stall_cycles_o           saturating count of cycles with pc_en_o low
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_branch_i,
  input  logic             id_is_jump_i,
  input  logic             id_is_md_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_mem_read_i,
  input  logic             md_done_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             md_start_o,
  output logic             md_error_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int TMO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

  // Comparator slots: 0 = load in EX, 1 = ALU write in EX, 2 = load in MEM.
  logic [4:0] cmp_rd    [3];
  logic       cmp_valid [3];
  logic [2:0] cmp_hit;

  assign cmp_rd[0]    = ex_rd_i;
  assign cmp_valid[0] = ex_mem_read_i;
  assign cmp_rd[1]    = ex_rd_i;
  assign cmp_valid[1] = ex_reg_write_i;
  assign cmp_rd[2]    = mem_rd_i;
  assign cmp_valid[2] = mem_mem_read_i;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
      pipeline_stall_ctrl_dep_cmp u_cmp (
        .rd_i      (cmp_rd[gi]),
        .valid_i   (cmp_valid[gi]),
        .rs_i      (id_rs_i),
        .rt_i      (id_rt_i),
        .uses_rt_i (id_uses_rt_i),
        .hit_o     (cmp_hit[gi])
      );
    end
  endgenerate

  logic [1:0] len;
  assign len = stall_len(id_is_branch_i, cmp_hit[0], cmp_hit[1], cmp_hit[2]);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             md_error_q, md_error_d;
  logic [CNT_W-1:0] stall_q;

  logic pc_en, ifid_en, ifid_flush, idex_bubble, md_start;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    md_error_d  = md_error_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (len != L_NONE) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          // This cycle is the first stall cycle; STALL covers the rest.
          if (len == L_TWO) begin
            state_d = ST_STALL;
            cnt_d   = 2'd1;
          end
        end else if (id_is_md_i) begin
          md_start    = 1'b1;
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = ST_MD_WAIT;
          tmo_d       = '0;
        end else begin
          ifid_flush = id_is_jump_i || (id_is_branch_i && branch_taken_i);
        end
      end

      ST_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      ST_MD_WAIT: begin
        // md_done releases the pipeline in the same cycle it arrives.
        if (!md_done_i) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (tmo_q == TMO_LAST) begin
            md_error_d = 1'b1;
            tmo_d      = '0;
            state_d    = ST_RUN;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end else begin
          tmo_d   = '0;
          state_d = ST_RUN;
        end
      end

      default: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        state_d     = ST_RUN;
      end
    endcase

    // Reset holds the front end and drains IF/ID and ID/EX.
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      md_start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= 2'd0;
      tmo_q      <= '0;
      md_error_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      md_error_q <= md_error_d;
      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign pc_en_o        = pc_en;
  assign ifid_en_o      = ifid_en;
  assign ifid_flush_o   = ifid_flush;
  assign idex_bubble_o  = idex_bubble;
  assign md_start_o     = md_start;
  assign md_error_o     = md_error_q;
  assign stall_cycles_o = stall_q;

endmodule
